// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
//   Turns accepted frame ticks into sprite position updates. On each accepted
//   tick in IDLE the movement requests are sampled and a clamped new origin is
//   computed. If the origin moved, the old sprite is erased and the new one is
//   drawn through a req/done handshake with the pixel-drawing FSM. Ticks that
//   arrive while a handshake is in progress are dropped and counted.
//
// Ports
//   clock        system clock, rising edge
//   resetn       asynchronous active-low reset
//   frame_tick   one-cycle pulse from the rate divider
//   enable       gates frame_tick; a gated tick is neither acted on nor counted
//   mv_left/right/up/down  movement requests, sampled on an accepted tick
//   draw_req     request to the draw engine
//   draw_erase   1 = erase at draw_x/draw_y, 0 = draw sprite there
//   draw_x/y     coordinate of the current request
//   draw_done    acknowledge from the draw engine
//   x, y         committed sprite origin
//   busy         high whenever a handshake is in progress
//   overrun_cnt  dropped-tick count, saturating at 15
module sprite_motion_ctrl #(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int X_MAX  = 152,
  parameter int Y_MAX  = 112,
  parameter int X_INIT = 0,
  parameter int Y_INIT = 0,
  parameter int STEP   = 1
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           frame_tick,
  input  logic           enable,
  input  logic           mv_left,
  input  logic           mv_right,
  input  logic           mv_up,
  input  logic           mv_down,
  output logic           draw_req,
  output logic           draw_erase,
  output logic [X_W-1:0] draw_x,
  output logic [Y_W-1:0] draw_y,
  input  logic           draw_done,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           busy,
  output logic [3:0]     overrun_cnt
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW} state_t;

  // Constants sized one bit wider than the coordinates so the step can never wrap.
  localparam logic [X_W:0]   X_MAX_E  = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0]   Y_MAX_E  = (Y_W+1)'(Y_MAX);
  localparam logic [X_W:0]   X_STEP_E = (X_W+1)'(STEP);
  localparam logic [Y_W:0]   Y_STEP_E = (Y_W+1)'(STEP);
  localparam logic [X_W-1:0] X_RST    = X_W'(X_INIT);
  localparam logic [Y_W-1:0] Y_RST    = Y_W'(Y_INIT);

  state_t         state, next_state;
  logic           tick_ok, xfer_done, moved;
  logic [X_W:0]   x_ext, nx_ext;
  logic [Y_W:0]   y_ext, ny_ext;
  logic [X_W-1:0] pend_x, pend_x_d, draw_x_d, x_d;
  logic [Y_W-1:0] pend_y, pend_y_d, draw_y_d, y_d;
  logic           draw_req_d, draw_erase_d;
  logic [3:0]     overrun_d;

  assign tick_ok   = frame_tick & enable;
  assign xfer_done = draw_req & draw_done;
  assign busy      = (state != IDLE);

  // Candidate next origin: opposite requests cancel, each axis saturates at 0
  // and at its maximum.
  always_comb begin
    x_ext  = {1'b0, x};
    y_ext  = {1'b0, y};
    nx_ext = x_ext;
    ny_ext = y_ext;
    if (mv_left && !mv_right)
      nx_ext = (x_ext >= X_STEP_E) ? x_ext - X_STEP_E : '0;
    else if (mv_right && !mv_left)
      nx_ext = (x_ext + X_STEP_E > X_MAX_E) ? X_MAX_E : x_ext + X_STEP_E;
    if (mv_up && !mv_down)
      ny_ext = (y_ext >= Y_STEP_E) ? y_ext - Y_STEP_E : '0;
    else if (mv_down && !mv_up)
      ny_ext = (y_ext + Y_STEP_E > Y_MAX_E) ? Y_MAX_E : y_ext + Y_STEP_E;
    moved = (nx_ext != x_ext) || (ny_ext != y_ext);
  end

  // State register; reset lands in DRAW so the sprite appears at its initial
  // origin as soon as reset releases.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= DRAW;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (tick_ok && moved) next_state = ERASE;
      ERASE:   if (xfer_done)        next_state = DRAW;
      DRAW:    if (xfer_done)        next_state = IDLE;
      default:                       next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs. On ERASE completion draw_req stays
  // high and only the fields change, so the draw request follows back to back.
  always_comb begin
    draw_req_d   = draw_req;
    draw_erase_d = draw_erase;
    draw_x_d     = draw_x;
    draw_y_d     = draw_y;
    x_d          = x;
    y_d          = y;
    pend_x_d     = pend_x;
    pend_y_d     = pend_y;
    overrun_d    = overrun_cnt;
    case (state)
      IDLE: begin
        if (tick_ok && moved) begin
          draw_req_d   = 1'b1;
          draw_erase_d = 1'b1;
          draw_x_d     = x;
          draw_y_d     = y;
          pend_x_d     = nx_ext[X_W-1:0];
          pend_y_d     = ny_ext[Y_W-1:0];
        end
      end
      ERASE: begin
        if (xfer_done) begin
          draw_erase_d = 1'b0;
          draw_x_d     = pend_x;
          draw_y_d     = pend_y;
          x_d          = pend_x;
          y_d          = pend_y;
        end
      end
      DRAW: begin
        if (xfer_done) draw_req_d = 1'b0;
      end
      default: draw_req_d = 1'b0;
    endcase
    if (tick_ok && state != IDLE && overrun_cnt != 4'hF)
      overrun_d = overrun_cnt + 4'd1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      draw_req    <= 1'b1;
      draw_erase  <= 1'b0;
      draw_x      <= X_RST;
      draw_y      <= Y_RST;
      x           <= X_RST;
      y           <= Y_RST;
      pend_x      <= X_RST;
      pend_y      <= Y_RST;
      overrun_cnt <= 4'd0;
    end else begin
      draw_req    <= draw_req_d;
      draw_erase  <= draw_erase_d;
      draw_x      <= draw_x_d;
      draw_y      <= draw_y_d;
      x           <= x_d;
      y           <= y_d;
      pend_x      <= pend_x_d;
      pend_y      <= pend_y_d;
      overrun_cnt <= overrun_d;
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl
//   Drives random and directed moves into sprite_motion_ctrl and compares the
//   handshake and committed position against a plain-arithmetic position model.
module tb_sprite_motion_ctrl;

  localparam int X_W = 8, Y_W = 7, X_MAX = 152, Y_MAX = 112;
  localparam int X_INIT = 10, Y_INIT = 20, STEP = 1;

  logic           clock = 1'b0;
  logic           resetn, frame_tick, enable;
  logic           mv_left, mv_right, mv_up, mv_down;
  logic           draw_req, draw_erase, draw_done, busy;
  logic [X_W-1:0] draw_x, x;
  logic [Y_W-1:0] draw_y, y;
  logic [3:0]     overrun_cnt;

  int errors = 0;
  int checks = 0;
  int mx, my, ovr;

  sprite_motion_ctrl #(
    .X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
    .X_INIT(X_INIT), .Y_INIT(Y_INIT), .STEP(STEP)
  ) dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .enable(enable),
    .mv_left(mv_left), .mv_right(mv_right), .mv_up(mv_up), .mv_down(mv_down),
    .draw_req(draw_req), .draw_erase(draw_erase), .draw_x(draw_x), .draw_y(draw_y),
    .draw_done(draw_done), .x(x), .y(y), .busy(busy), .overrun_cnt(overrun_cnt)
  );

  always #5 clock = ~clock;

  function automatic int step_axis(input int v, input bit dec, input bit inc, input int hi);
    int r;
    r = v;
    if (dec && !inc) r = v - STEP;
    if (inc && !dec) r = v + STEP;
    if (r < 0) r = 0;
    if (r > hi) r = hi;
    return r;
  endfunction

  // One tick in IDLE followed by a full handshake with random acknowledge delay.
  task automatic move(input bit l, input bit r, input bit u, input bit d);
    int nx, ny;
    nx = step_axis(mx, l, r, X_MAX);
    ny = step_axis(my, u, d, Y_MAX);
    @(negedge clock);
    frame_tick = 1; enable = 1; draw_done = 0;
    mv_left = l; mv_right = r; mv_up = u; mv_down = d;
    @(negedge clock);
    frame_tick = 0; mv_left = 0; mv_right = 0; mv_up = 0; mv_down = 0;
    checks++;
    if (nx == mx && ny == my) begin
      if (draw_req !== 1'b0 || busy !== 1'b0 || x !== mx || y !== my) begin
        errors++;
        $display("FAIL no_move: req=%0b busy=%0b x=%0d y=%0d expected req=0 busy=0 x=%0d y=%0d",
                 draw_req, busy, x, y, mx, my);
      end
      return;
    end
    if (draw_req !== 1'b1 || draw_erase !== 1'b1 || draw_x !== mx || draw_y !== my) begin
      errors++;
      $display("FAIL erase_req: req=%0b erase=%0b at (%0d,%0d) expected req=1 erase=1 at (%0d,%0d)",
               draw_req, draw_erase, draw_x, draw_y, mx, my);
    end
    repeat ($urandom_range(0, 3)) begin
      @(negedge clock);
      checks++;
      if (draw_req !== 1'b1 || draw_erase !== 1'b1 || draw_x !== mx || x !== mx || y !== my) begin
        errors++;
        $display("FAIL erase_hold: req=%0b erase=%0b draw_x=%0d x=%0d y=%0d expected x=%0d y=%0d",
                 draw_req, draw_erase, draw_x, x, y, mx, my);
      end
    end
    draw_done = 1;
    @(negedge clock);
    draw_done = 0;
    checks++;
    if (draw_req !== 1'b1 || draw_erase !== 1'b0 || draw_x !== nx || draw_y !== ny ||
        x !== nx || y !== ny) begin
      errors++;
      $display("FAIL draw_req: req=%0b erase=%0b at (%0d,%0d) pos (%0d,%0d) expected req=1 erase=0 at (%0d,%0d)",
               draw_req, draw_erase, draw_x, draw_y, x, y, nx, ny);
    end
    repeat ($urandom_range(0, 2)) @(negedge clock);
    draw_done = 1;
    @(negedge clock);
    draw_done = 0;
    checks++;
    if (draw_req !== 1'b0 || busy !== 1'b0 || overrun_cnt !== ovr) begin
      errors++;
      $display("FAIL draw_end: req=%0b busy=%0b overrun=%0d expected req=0 busy=0 overrun=%0d",
               draw_req, busy, overrun_cnt, ovr);
    end
    mx = nx; my = ny;
  endtask

  task automatic goto_pos(input int tx, input int ty);
    while (mx != tx || my != ty) move(mx > tx, mx < tx, my > ty, my < ty);
  endtask

  task automatic test_reset;
    bit idle_seen;
    resetn = 0; frame_tick = 0; enable = 1; draw_done = 1;
    mv_left = 0; mv_right = 0; mv_up = 0; mv_down = 0;
    @(negedge clock);
    checks++;
    if (draw_req !== 1'b1 || draw_erase !== 1'b0 || draw_x !== X_INIT || draw_y !== Y_INIT ||
        x !== X_INIT || y !== Y_INIT || busy !== 1'b1 || overrun_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: req=%0b erase=%0b draw=(%0d,%0d) pos=(%0d,%0d) busy=%0b ovr=%0d",
               draw_req, draw_erase, draw_x, draw_y, x, y, busy, overrun_cnt);
    end
    resetn = 1;
    idle_seen = 0;
    for (int i = 0; i < 3 && !idle_seen; i++) begin
      @(negedge clock);
      if (busy === 1'b0 && draw_req === 1'b0) idle_seen = 1;
    end
    draw_done = 0;
    checks++;
    if (!idle_seen) begin
      errors++;
      $display("FAIL reset_idle: busy=%0b req=%0b expected busy=0 req=0 within 3 cycles", busy, draw_req);
    end
    mx = X_INIT; my = Y_INIT; ovr = 0;
    move(0, 1, 0, 0);
  endtask

  task automatic test_enable;
    @(negedge clock);
    frame_tick = 1; enable = 0; mv_right = 1;
    @(negedge clock);
    frame_tick = 0; enable = 1; mv_right = 0;
    checks++;
    if (draw_req !== 1'b0 || busy !== 1'b0 || x !== mx || overrun_cnt !== ovr) begin
      errors++;
      $display("FAIL enable_gate: req=%0b busy=%0b x=%0d ovr=%0d expected req=0 busy=0 x=%0d ovr=%0d",
               draw_req, busy, x, overrun_cnt, mx, ovr);
    end
  endtask

  task automatic test_random_moves;
    logic [3:0] dirs;
    for (int i = 0; i < 40; i++) begin
      dirs = 4'($urandom_range(0, 15));
      move(dirs[0], dirs[1], dirs[2], dirs[3]);
    end
  endtask

  task automatic test_clamp;
    goto_pos(0, 5);
    move(1, 0, 0, 0);
    goto_pos(X_MAX, 5);
    move(0, 1, 0, 0);
    goto_pos(X_MAX, 0);
    move(0, 0, 1, 0);
    goto_pos(X_MAX, Y_MAX);
    move(0, 0, 0, 1);
  endtask

  task automatic test_diagonal;
    goto_pos(40, 40);
    move(1, 1, 0, 1);
  endtask

  // A tick landing on the cycle DRAW completes is dropped; the next one is taken.
  task automatic test_back_to_back;
    @(negedge clock);
    frame_tick = 1; mv_right = 1; draw_done = 1;
    @(negedge clock);
    frame_tick = 0; mv_right = 0;
    @(negedge clock);
    frame_tick = 1; mv_right = 1;
    @(negedge clock);
    frame_tick = 1; mv_right = 1; draw_done = 0;
    mx = mx + 1; ovr = ovr + 1;
    checks++;
    if (busy !== 1'b0 || x !== mx || overrun_cnt !== ovr) begin
      errors++;
      $display("FAIL b2b_drop: busy=%0b x=%0d ovr=%0d expected busy=0 x=%0d ovr=%0d",
               busy, x, overrun_cnt, mx, ovr);
    end
    @(negedge clock);
    frame_tick = 0; mv_right = 0;
    checks++;
    if (draw_req !== 1'b1 || draw_erase !== 1'b1 || draw_x !== mx) begin
      errors++;
      $display("FAIL b2b_accept: req=%0b erase=%0b draw_x=%0d expected req=1 erase=1 draw_x=%0d",
               draw_req, draw_erase, draw_x, mx);
    end
    draw_done = 1;
    repeat (2) @(negedge clock);
    draw_done = 0;
    mx = mx + 1;
    checks++;
    if (busy !== 1'b0 || x !== mx) begin
      errors++;
      $display("FAIL b2b_end: busy=%0b x=%0d expected busy=0 x=%0d", busy, x, mx);
    end
  endtask

  task automatic test_overrun;
    int ny, ticks;
    ny = (my < Y_MAX) ? my + 1 : my - 1;
    @(negedge clock);
    frame_tick = 1; draw_done = 0;
    mv_down = (my < Y_MAX); mv_up = (my == Y_MAX);
    @(negedge clock);
    frame_tick = 0; mv_down = 0; mv_up = 0;
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      frame_tick = (i % 5 == 0);
      mv_left = 1'($urandom); mv_right = 1'($urandom);
      mv_up = 1'($urandom); mv_down = 1'($urandom);
      if (frame_tick) ticks++;
      @(negedge clock);
      checks++;
      if (draw_req !== 1'b1 || draw_erase !== 1'b1 || x !== mx || y !== my) begin
        errors++;
        $display("FAIL overrun_hold: req=%0b erase=%0b pos=(%0d,%0d) expected (%0d,%0d)",
                 draw_req, draw_erase, x, y, mx, my);
      end
    end
    frame_tick = 0; mv_left = 0; mv_right = 0; mv_up = 0; mv_down = 0;
    ovr = (ovr + ticks > 15) ? 15 : ovr + ticks;
    checks++;
    if (overrun_cnt !== ovr) begin
      errors++;
      $display("FAIL overrun_sat: got %0d expected %0d", overrun_cnt, ovr);
    end
    draw_done = 1;
    @(negedge clock);
    checks++;
    if (y !== ny || draw_y !== ny || draw_erase !== 1'b0) begin
      errors++;
      $display("FAIL overrun_commit: y=%0d draw_y=%0d erase=%0b expected y=%0d erase=0",
               y, draw_y, draw_erase, ny);
    end
    @(negedge clock);
    draw_done = 0;
    my = ny;
  endtask

  task automatic test_reset_mid_erase;
    bit bad_draw;
    goto_pos(X_INIT, Y_INIT);
    @(negedge clock);
    frame_tick = 1; mv_right = 1; draw_done = 0;
    @(negedge clock);
    frame_tick = 0; mv_right = 0;
    checks++;
    if (draw_req !== 1'b1 || draw_erase !== 1'b1 || draw_x !== X_INIT) begin
      errors++;
      $display("FAIL rst_mid_erase: req=%0b erase=%0b draw_x=%0d", draw_req, draw_erase, draw_x);
    end
    repeat (2) @(negedge clock);
    #2 resetn = 0;
    #1;
    checks++;
    if (draw_req !== 1'b1 || draw_erase !== 1'b0 || busy !== 1'b1 || overrun_cnt !== 4'd0 ||
        draw_x !== X_INIT || draw_y !== Y_INIT) begin
      errors++;
      $display("FAIL rst_async: req=%0b erase=%0b busy=%0b ovr=%0d draw=(%0d,%0d)",
               draw_req, draw_erase, busy, overrun_cnt, draw_x, draw_y);
    end
    @(negedge clock);
    resetn = 1;
    bad_draw = 0;
    repeat (3) begin
      @(negedge clock);
      if (draw_req === 1'b1 && (draw_x !== X_INIT || draw_erase !== 1'b0)) bad_draw = 1;
    end
    checks++;
    if (bad_draw) begin
      errors++;
      $display("FAIL rst_no_stale: saw draw_x=%0d erase=%0b expected %0d erase=0",
               draw_x, draw_erase, X_INIT);
    end
    draw_done = 1;
    @(negedge clock);
    draw_done = 0;
    checks++;
    if (busy !== 1'b0 || draw_req !== 1'b0 || x !== X_INIT || y !== Y_INIT) begin
      errors++;
      $display("FAIL rst_recover: busy=%0b req=%0b pos=(%0d,%0d) expected (%0d,%0d)",
               busy, draw_req, x, y, X_INIT, Y_INIT);
    end
    mx = X_INIT; my = Y_INIT; ovr = 0;
    move(0, 0, 0, 1);
  endtask

  initial begin
    test_reset;
    test_enable;
    test_random_moves;
    test_clamp;
    test_diagonal;
    test_back_to_back;
    test_overrun;
    test_reset_mid_erase;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Consumes the single-cycle frame pulses produced by the rate dividers and turns them into sprite position updates for the VGA draw engine. On each accepted frame tick it samples the movement inputs and computes a clamped new position. If the position changed, it runs an erase-old / draw-new handshake with the drawing datapath. It sits between the frame-tick generator, the player input logic and the pixel-drawing FSM.

## Interface
- X_W, 8, width of x coordinate
- Y_W, 7, width of y coordinate
- X_MAX, 152, largest legal x (sprite origin)
- Y_MAX, 112, largest legal y (sprite origin)
- X_INIT, 0, x after reset
- Y_INIT, 0, y after reset
- STEP, 1, pixels moved per accepted tick

- clock  in  1  system clock; everything is clocked on its rising edge
- resetn  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse from the rate divider
- enable  in  1  when 0, ticks are ignored and neither counted nor acted on
- mv_left, mv_right, mv_up, mv_down  in  1 each  movement requests, sampled only on an accepted tick
- draw_req  out  1  request to the draw engine
- draw_erase  out  1  1 = erase at draw_x/draw_y, 0 = draw sprite there
- draw_x  out  X_W  coordinate for the current request
- draw_y  out  Y_W  coordinate for the current request
- draw_done  in  1  acknowledge from the draw engine
- x  out  X_W  committed sprite x
- y  out  Y_W  committed sprite y
- busy  out  1  high whenever state is not IDLE
- overrun_cnt  out  4  count of dropped ticks; saturates at 15

## Operation
- States: IDLE, ERASE, DRAW. Outputs are registered.
- Reset (asynchronous, takes effect immediately):
  - state = DRAW, draw_req = 1, draw_erase = 0
  - draw_x = X_INIT, draw_y = Y_INIT, x = X_INIT, y = Y_INIT
  - overrun_cnt = 0
  - Result: the sprite is drawn once at its initial position after reset releases.
- Accepted tick: frame_tick = 1 and enable = 1.
- Accepted tick in IDLE:
  - Compute nx, ny as follows:
    - mv_left and mv_right both 1: x unchanged.
    - mv_left only: nx = x − STEP, saturating at 0.
    - mv_right only: nx = x + STEP, saturating at X_MAX.
    - y uses the same rules: mv_up decrements, mv_down increments, saturating at Y_MAX.
  - Arithmetic is carried out one bit wider than the coordinate, so no wrap-around can occur.
  - If (nx, ny) = (x, y): stay in IDLE and issue no request.
  - Otherwise: latch (nx, ny) as the pending position and go to ERASE with draw_erase = 1, draw_x = x, draw_y = y.
- ERASE: hold draw_req until draw_done = 1 is seen. Then:
  - Go to DRAW.
  - Commit x, y ← pending.
  - Set draw_erase = 0 and draw_x/draw_y = pending.
- DRAW: hold draw_req until draw_done = 1 is seen, then go to IDLE.
- Accepted tick in ERASE or DRAW:
  - The tick is dropped; movement inputs are not sampled.
  - overrun_cnt increments, saturating at 15.
- draw_done while draw_req = 0 is ignored.
- enable is not sampled outside tick cycles; an in-progress handshake always completes.

## Timing
- Handshake:
  - draw_req, draw_erase, draw_x and draw_y stay stable while draw_req = 1.
  - A transfer completes in the cycle where draw_req = 1 and draw_done = 1.
  - draw_req drops in the next cycle, except on an ERASE→DRAW transition, where it stays high and the fields change.
- Tick accepted in cycle T (state IDLE):
  - ERASE request is visible from T+1.
  - If ERASE completes in cycle D, the DRAW request and the new x, y are visible from D+1.
  - If DRAW completes in cycle E, state is IDLE, busy = 0 and draw_req = 0 from E+1.
- A tick in cycle E+1 or later is accepted.
- A tick coinciding with the completing cycle E is dropped (state is still DRAW).
- Minimum tick-to-IDLE time is 3 cycles, with draw_done held high.
- Reset asserted mid-handshake: draw_req and busy stay at their reset values until release. No pending position survives reset.

## Test plan
- Reset with X_INIT=10, Y_INIT=20, draw_done tied to 1 → request (10,20) with erase=0 is accepted; IDLE, busy=0 three cycles after release.
- At (10,20), tick with mv_right → ERASE (10,20) erase=1, then DRAW (11,20) erase=0; x=11 from the cycle after the erase is accepted.
- At (0,5), tick with mv_left → no draw_req, x stays 0; at (152,5) with mv_right → no draw_req.
- Tick with mv_left+mv_right+mv_down at (40,40) → erase (40,40), draw (40,41).
- draw_done held 0 for 100 cycles during ERASE, with 20 ticks applied → overrun_cnt = 15 (saturated), position unchanged until draw_done rises.
- resetn pulsed low mid-ERASE (after a move from (10,20) to (11,20)) → draw_req and overrun_cnt reset; after release, draw (X_INIT, Y_INIT) erase=0; no (11,20) ever drawn.
